// File: rtl/cfg_chain_loader.sv
`timescale 1ns/1ps
// Serial configuration loader: host words arrive over valid/ready and are shifted LSB-first into the chain head.
// Bits returning from the chain tail are captured into per-word readback words.
module cfg_chain_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32
) (
  input  logic              Config_Clock,
  input  logic              Config_Reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ConfigOut,
  output logic              ConfigShift,
  input  logic              ConfigIn,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int NWORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LASTBITS = CHAIN_LEN - WORD_W * (NWORDS - 1);
  localparam int WCW      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BCW      = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            r_state, w_next;
  logic [WCW-1:0]    r_word_cnt;
  logic [BCW-1:0]    r_bit_cnt, r_bit_tgt;
  logic [WORD_W-1:0] r_shift, r_rb, r_rb_data;
  logic              r_rb_valid;
  logic              w_last_bit, w_last_word;
  logic [WORD_W-1:0] w_rb_next;

  assign w_last_word = (r_word_cnt == WCW'(NWORDS - 1));
  assign w_last_bit  = (r_state == SHIFT) && (r_bit_cnt == r_bit_tgt - BCW'(1));
  // Tail bit lands at its index within the word; untouched positions stay zero.
  assign w_rb_next   = r_rb | (WORD_W'(ConfigIn) << r_bit_cnt);

  always_ff @(posedge Config_Clock or negedge Config_Reset) begin
    if (!Config_Reset) r_state <= IDLE;
    else               r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    if (word_valid) w_next = SHIFT;
      SHIFT:   if (w_last_bit) w_next = w_last_word ? DONE : LOAD;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != IDLE);
    word_ready  = (r_state == LOAD);
    ConfigShift = (r_state == SHIFT);
    ConfigOut   = (r_state == SHIFT) && r_shift[0];
    done        = (r_state == DONE);
  end

  always_ff @(posedge Config_Clock or negedge Config_Reset) begin
    if (!Config_Reset) begin
      r_word_cnt <= '0;
      r_bit_cnt  <= '0;
      r_bit_tgt  <= '0;
      r_shift    <= '0;
      r_rb       <= '0;
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_word_cnt <= '0;
            r_bit_cnt  <= '0;
          end
        end
        LOAD: begin
          if (word_valid) begin
            r_shift   <= word_data;
            r_rb      <= '0;
            r_bit_cnt <= '0;
            r_bit_tgt <= w_last_word ? BCW'(LASTBITS) : BCW'(WORD_W);
          end
        end
        SHIFT: begin
          r_shift   <= r_shift >> 1;
          r_rb      <= w_rb_next;
          r_bit_cnt <= r_bit_cnt + BCW'(1);
          if (w_last_bit) begin
            r_rb_data  <= w_rb_next;
            r_rb_valid <= 1'b1;
            r_word_cnt <= r_word_cnt + WCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rb_data  = r_rb_data;
  assign rb_valid = r_rb_valid;

endmodule

// File: tb/tb_cfg_chain_loader.sv
`timescale 1ns/1ps
// Directed bench: a 64-bit and a 40-bit loader instance, each looped through a model chain.
module tb_cfg_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          total = 0;
  int          bad   = 0;
  int          sel;
  logic        start_m, valid_m;
  logic [31:0] data_m;

  logic        a_start, a_busy, a_done, a_valid, a_ready, a_out, a_shift, a_in, a_rbv;
  logic [31:0] a_rb;
  logic        b_start, b_busy, b_done, b_valid, b_ready, b_out, b_shift, b_in, b_rbv;
  logic [31:0] b_rb;

  assign a_start = start_m & (sel == 0);
  assign a_valid = valid_m & (sel == 0);
  assign b_start = start_m & (sel != 0);
  assign b_valid = valid_m & (sel != 0);

  cfg_chain_loader #(.CHAIN_LEN(64), .WORD_W(32)) u_a (
    .Config_Clock(clk), .Config_Reset(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .word_data(data_m), .word_valid(a_valid), .word_ready(a_ready), .ConfigOut(a_out),
    .ConfigShift(a_shift), .ConfigIn(a_in), .rb_data(a_rb), .rb_valid(a_rbv));

  cfg_chain_loader #(.CHAIN_LEN(40), .WORD_W(32)) u_b (
    .Config_Clock(clk), .Config_Reset(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .word_data(data_m), .word_valid(b_valid), .word_ready(b_ready), .ConfigOut(b_out),
    .ConfigShift(b_shift), .ConfigIn(b_in), .rb_data(b_rb), .rb_valid(b_rbv));

  // Model chains: index 0 is the tail, new bits enter at the top.
  logic [63:0] chain_a;
  logic [39:0] chain_b;
  logic        pre_a, pre_b;
  logic [63:0] pre_val;
  always @(posedge clk) begin
    if (pre_a)        chain_a <= pre_val;
    else if (a_shift) chain_a <= {a_out, chain_a[63:1]};
    if (pre_b)        chain_b <= pre_val[39:0];
    else if (b_shift) chain_b <= {b_out, chain_b[39:1]};
  end
  assign a_in = chain_a[0];
  assign b_in = chain_b[0];

  wire        m_busy  = (sel != 0) ? b_busy  : a_busy;
  wire        m_done  = (sel != 0) ? b_done  : a_done;
  wire        m_ready = (sel != 0) ? b_ready : a_ready;
  wire        m_shift = (sel != 0) ? b_shift : a_shift;
  wire        m_out   = (sel != 0) ? b_out   : a_out;
  wire        m_rbv   = (sel != 0) ? b_rbv   : a_rbv;
  wire [31:0] m_rb    = (sel != 0) ? b_rb    : a_rb;

  int          done_cyc, n_shift, nruns, nrb;
  int          runs[4];
  int          rb_cyc[4];
  logic [31:0] rbw[4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [63:0] v, input bit to_b);
    @(negedge clk);
    pre_val = v;
    pre_a   = !to_b;
    pre_b   = to_b;
    @(negedge clk);
    pre_a = 1'b0;
    pre_b = 1'b0;
  endtask

  // Cycle numbering: the start cycle is 0, observations are taken on the falling edge.
  task automatic run_load(input logic [31:0] wa, input logic [31:0] wb, input int stall, input int abort_at);
    int k;
    int run;
    int stall_left;
    bit stall_on;
    k = 0; run = 0; stall_left = stall; stall_on = 1'b0;
    done_cyc = -1; n_shift = 0; nruns = 0; nrb = 0;
    @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    chk("ready_t1", m_ready, 1);
    chk("busy_t1", m_busy, 1);
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (m_shift) begin
        n_shift++;
        run++;
      end else if (run > 0) begin
        if (nruns < 4) runs[nruns] = run;
        nruns++;
        run = 0;
      end
      if (m_rbv) begin
        if (nrb < 4) begin
          rbw[nrb]    = m_rb;
          rb_cyc[nrb] = cyc;
        end
        nrb++;
      end
      if (abort_at > 0 && n_shift == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_busy", m_busy, 0);
        chk("abort_shift", m_shift, 0);
        chk("abort_out", m_out, 0);
        chk("abort_ready", m_ready, 0);
        chk("abort_rb", {m_rbv, m_rb}, 0);
        valid_m = 1'b0;
        return;
      end
      if (m_done) begin
        done_cyc = cyc;
        chk("rbv_with_done", m_rbv, 1);
        valid_m = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", m_done, 0);
        chk("busy_after_done", m_busy, 0);
        chk("rbv_one_cycle", m_rbv, 0);
        return;
      end
      if (k < 2) begin
        data_m = (k == 0) ? wa : wb;
        if (k == 1 && stall_left > 0) begin
          valid_m = 1'b0;
          if (stall_on || m_ready) begin
            stall_on = 1'b1;
            chk("stall_ready", m_ready, 1);
            chk("stall_shift", m_shift, 0);
            stall_left--;
          end
        end else begin
          valid_m = 1'b1;
        end
        if (m_ready && valid_m) k++;
      end else begin
        valid_m = 1'b0;
      end
    end
    chk("done_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; sel = 0; start_m = 1'b0; valid_m = 1'b0; data_m = '0;
    pre_a = 1'b1; pre_b = 1'b1; pre_val = '0;

    // Reset held: start toggling must not wake either instance.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_m = ~start_m;
      sel = i % 2;
      #1;
      chk("rst_outs_a", {a_busy, a_done, a_ready, a_out, a_shift, a_rbv, a_rb}, 0);
      chk("rst_outs_b", {b_busy, b_done, b_ready, b_out, b_shift, b_rbv, b_rb}, 0);
    end
    @(negedge clk);
    start_m = 1'b0; pre_a = 1'b0; pre_b = 1'b0; sel = 0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", a_ready, 0);
    chk("idle_busy", a_busy, 0);

    // Basic 64-bit load, chain starts at zero.
    sel = 0;
    run_load(32'hDEADBEEF, 32'h12345678, 0, 0);
    chk("basic_done_cyc", done_cyc, 67);
    chk("basic_nshift", n_shift, 64);
    chk("basic_runs", {runs[0][31:0], runs[1][31:0]}, {32'd32, 32'd32});
    chk("basic_chain", chain_a, 64'h12345678_DEADBEEF);
    chk("basic_rb_cyc", {rb_cyc[0][31:0], rb_cyc[1][31:0]}, {32'd34, 32'd67});
    chk("basic_rb", {rbw[0], rbw[1]}, 64'h0);

    // Partial last word on the 40-bit chain with preloaded readback.
    preload(64'h00000000_A5_12345678, 1'b1);
    sel = 1;
    run_load(32'hFFFFFFFF, 32'hABCDEF5A, 0, 0);
    chk("part_done_cyc", done_cyc, 43);
    chk("part_nshift", n_shift, 40);
    chk("part_runs", {runs[0][31:0], runs[1][31:0]}, {32'd32, 32'd8});
    chk("part_chain", chain_b, 40'h5A_FFFFFFFF);
    chk("part_rb", {rbw[0], rbw[1]}, 64'h12345678_000000A5);

    // Five-cycle stall between words.
    sel = 0;
    preload(64'h0, 1'b0);
    run_load(32'h0F0F0F0F, 32'h13579BDF, 5, 0);
    chk("stall_done_cyc", done_cyc, 72);
    chk("stall_nshift", n_shift, 64);
    chk("stall_chain", chain_a, 64'h13579BDF_0F0F0F0F);

    // Readback of previous contents.
    preload(64'h0000CAFE_00000001, 1'b0);
    run_load(32'h11111111, 32'h22222222, 0, 0);
    chk("rb_count", nrb, 2);
    chk("rb_words", {rbw[0], rbw[1]}, 64'h00000001_0000CAFE);
    chk("rb_chain", chain_a, 64'h22222222_11111111);

    // Abort after 10 shifts, then a clean reload.
    run_load(32'hA5A5A5A5, 32'h5A5A5A5A, 0, 10);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_abort_idle", {a_busy, a_ready, a_shift}, 0);
    run_load(32'hCAFEF00D, 32'h0BADBEEF, 0, 0);
    chk("reload_done_cyc", done_cyc, 67);
    chk("reload_nshift", n_shift, 64);
    chk("reload_chain", chain_a, 64'h0BADBEEF_CAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
